sram_tile_reader: RTL and testbench

SRAM_TILE_READER -- requirements
Module: sram_tile_reader

---
 rtl/sram_tile_reader_pkg.sv | 13 +
 rtl/sram_tile_reader_if.sv | 23 ++
 rtl/sram_tile_reader_tile_fifo2.sv | 44 ++++
 rtl/sram_tile_reader.sv | 119 +++++++++++
 tb/tb_sram_tile_reader.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/sram_tile_reader_pkg.sv
// Shared constants and FSM encoding for the GEMM tile reader.
package sram_tile_reader_pkg;
   localparam int DEF_ADDR_WIDTH = 16;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_DIM_WIDTH  = 8;
   localparam int FIFO_DEPTH     = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;
endpackage

// File: rtl/sram_tile_reader_if.sv
// SRAM read port plus element stream toward the GEMM array.
interface sram_tile_reader_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32
);
   logic                  sram_re;
   logic [ADDR_WIDTH-1:0] sram_addr;
   logic [DATA_WIDTH-1:0] sram_rdata;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_last_col;
   logic                  out_last;

   modport master (
      output sram_re, sram_addr, out_valid, out_data, out_last_col, out_last,
      input  sram_rdata, out_ready
   );
   modport slave (
      input  sram_re, sram_addr, out_valid, out_data, out_last_col, out_last,
      output sram_rdata, out_ready
   );
endinterface

// File: rtl/sram_tile_reader_tile_fifo2.sv
// Two-entry FIFO for returned SRAM words and their tags; push and pop may coincide.
module tile_fifo2 #(
   parameter int WIDTH = 34
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   logic [1:0][WIDTH-1:0] mem;
   logic                  wr_ptr, rd_ptr;
   logic [1:0]            count;
   logic                  do_push, do_pop;

   assign full    = (count == 2'd2);
   assign empty   = (count == 2'd0);
   assign dout    = mem[rd_ptr];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem    <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop) rd_ptr <= ~rd_ptr;
         case ({do_push, do_pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/sram_tile_reader.sv
// Streams a rows x cols tile out of SRAM in row-major order with backpressure-safe read credits.
module sram_tile_reader
   import sram_tile_reader_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DIM_WIDTH  = DEF_DIM_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [DIM_WIDTH-1:0]  rows,
   input  logic [DIM_WIDTH-1:0]  cols,
   input  logic [ADDR_WIDTH-1:0] row_stride,
   output logic                  busy,
   output logic                  done,
   sram_tile_reader_if.master    bus
);
   state_t                state, state_nxt;
   logic [DIM_WIDTH-1:0]  rows_q, cols_q, row_cnt, col_cnt;
   logic [ADDR_WIDTH-1:0] stride_q, row_base, cur_addr, last_addr;
   logic                  infl;
   logic [1:0]            infl_tag;
   logic                  re, accept, empty_tile, pop, head_last;
   logic                  issue_last_col, issue_last;
   logic                  fifo_full, fifo_empty;
   logic [2:0]            used;
   logic [DATA_WIDTH+1:0] head;

   assign accept     = (state == ST_IDLE) && start && (rows != '0) && (cols != '0);
   assign empty_tile = (state == ST_IDLE) && start && ((rows == '0) || (cols == '0));
   assign pop        = !fifo_empty && bus.out_ready;
   assign head_last  = head[DATA_WIDTH+1];

   assign issue_last_col = (col_cnt == cols_q - DIM_WIDTH'(1));
   assign issue_last     = issue_last_col && (row_cnt == rows_q - DIM_WIDTH'(1));

   // Credits count the slot freed by this cycle's pop, so a full-rate stream never stalls.
   assign used = (fifo_full ? 3'd2 : (fifo_empty ? 3'd0 : 3'd1)) + {2'b0, infl} - {2'b0, pop};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (accept) state_nxt = ST_ISSUE;
         ST_ISSUE: if (re && issue_last) state_nxt = ST_DRAIN;
         ST_DRAIN: if (pop && head_last) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      busy = (state != ST_IDLE);
      re   = (state == ST_ISSUE) && (used < 3'd2);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rows_q    <= '0;
         cols_q    <= '0;
         stride_q  <= '0;
         row_cnt   <= '0;
         col_cnt   <= '0;
         row_base  <= '0;
         cur_addr  <= '0;
         last_addr <= '0;
         infl      <= 1'b0;
         infl_tag  <= 2'b0;
         done      <= 1'b0;
      end else begin
         infl     <= re;
         infl_tag <= {issue_last, issue_last_col};
         done     <= ((state == ST_DRAIN) && pop && head_last) || empty_tile;
         if (accept) begin
            rows_q   <= rows;
            cols_q   <= cols;
            stride_q <= row_stride;
            row_cnt  <= '0;
            col_cnt  <= '0;
            row_base <= base_addr;
            cur_addr <= base_addr;
         end else if (re) begin
            last_addr <= cur_addr;
            if (issue_last_col) begin
               col_cnt  <= '0;
               row_cnt  <= row_cnt + DIM_WIDTH'(1);
               row_base <= row_base + stride_q;
               cur_addr <= row_base + stride_q;
            end else begin
               col_cnt  <= col_cnt + DIM_WIDTH'(1);
               cur_addr <= cur_addr + ADDR_WIDTH'(1);
            end
         end
      end
   end

   tile_fifo2 #(.WIDTH(DATA_WIDTH + 2)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (infl),
      .din     ({infl_tag, bus.sram_rdata}),
      .pop     (pop),
      .dout    (head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign bus.sram_re      = re;
   assign bus.sram_addr    = re ? cur_addr : last_addr;
   assign bus.out_valid    = !fifo_empty;
   assign bus.out_data     = head[DATA_WIDTH-1:0];
   assign bus.out_last_col = head[DATA_WIDTH];
   assign bus.out_last     = head[DATA_WIDTH+1];
endmodule

// File: tb/tb_sram_tile_reader.sv
// Directed and randomized tiles checked against an address/data model of the tile walk.
module tb_sram_tile_reader;
   localparam int AW = 16;
   localparam int DW = 32;
   localparam int DMW = 8;

   logic           clk = 1'b0;
   logic           reset_n = 1'b0;
   logic           start = 1'b0;
   logic [AW-1:0]  base_addr = '0;
   logic [AW-1:0]  row_stride = '0;
   logic [DMW-1:0] rows = '0;
   logic [DMW-1:0] cols = '0;
   logic           busy, done;

   sram_tile_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   sram_tile_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DIM_WIDTH(DMW)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .base_addr  (base_addr),
      .rows       (rows),
      .cols       (cols),
      .row_stride (row_stride),
      .busy       (busy),
      .done       (done),
      .bus        (bus.master)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int errors  = 0;
   int cyc     = 0;
   int rdy_mode = 0;

   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
      return {~a, a} ^ 32'h3C5A_0F96;
   endfunction

   // SRAM with one-cycle read latency
   always @(posedge clk) if (bus.sram_re) bus.sram_rdata <= mem_word(bus.sram_addr);

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       bus.out_ready = 1'b1;
         1:       bus.out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
         default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
   end

   logic [AW-1:0]   rd_q[$];
   int              rd_cyc[$];
   logic [DW+1:0]   pop_q[$];
   int              pop_cyc[$];
   int              done_cyc[$];
   bit              busy_seen, done_busy, prev_stall;
   logic [DW-1:0]   prev_data;
   int              issued, popped, max_out, stall_bad;

   always @(negedge clk) if (reset_n) begin
      if (bus.sram_re) begin
         rd_q.push_back(bus.sram_addr);
         rd_cyc.push_back(cyc);
         issued++;
      end
      if (bus.out_valid && bus.out_ready) begin
         pop_q.push_back({bus.out_last, bus.out_last_col, bus.out_data});
         pop_cyc.push_back(cyc);
         popped++;
      end
      if (issued - popped > max_out) max_out = issued - popped;
      if (prev_stall && bus.out_data !== prev_data) stall_bad++;
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      if (done) begin
         done_cyc.push_back(cyc);
         done_busy = busy;
      end
      if (busy) busy_seen = 1'b1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_log();
      rd_q.delete(); rd_cyc.delete(); pop_q.delete(); pop_cyc.delete(); done_cyc.delete();
      issued = 0; popped = 0; max_out = 0; stall_bad = 0;
      busy_seen = 1'b0; done_busy = 1'b0; prev_stall = 1'b0;
   endtask

   task automatic chk_outputs_zero(input string name);
      chk({name, "/sram_re"},   64'(bus.sram_re), 0);
      chk({name, "/sram_addr"}, 64'(bus.sram_addr), 0);
      chk({name, "/out_valid"}, 64'(bus.out_valid), 0);
      chk({name, "/out_data"},  64'(bus.out_data), 0);
      chk({name, "/last_col"},  64'(bus.out_last_col), 0);
      chk({name, "/last"},      64'(bus.out_last), 0);
      chk({name, "/busy"},      64'(busy), 0);
      chk({name, "/done"},      64'(done), 0);
   endtask

   task automatic run_tile(input string name, input logic [AW-1:0] b, input int r, input int c,
                           input logic [AW-1:0] s, input bit poke, input bit strict);
      int st, k, idx, n;
      logic [AW-1:0] ea;
      logic [DW+1:0] ee;
      clear_log();
      @(posedge clk); #1;
      start = 1'b1; base_addr = b; rows = DMW'(r); cols = DMW'(c); row_stride = s;
      st = cyc;
      @(posedge clk); #1;
      start = 1'b0; base_addr = AW'($urandom); rows = DMW'($urandom); cols = DMW'($urandom);
      row_stride = AW'($urandom);
      k = 0;
      while (done_cyc.size() == 0 && k < 2000) begin
         start = poke && (k == 2);
         if (start) begin base_addr = 16'h7777; rows = 8'd3; cols = 8'd3; row_stride = 16'h5; end
         @(posedge clk); #1;
         k++;
      end
      start = 1'b0;
      chk({name, "/done_seen"}, 64'(done_cyc.size() > 0), 1);
      if (done_cyc.size() == 0) return;
      n = r * c;
      chk({name, "/busy_after"}, 64'(busy), 0);
      chk({name, "/busy_at_done"}, 64'(done_busy), 0);
      chk({name, "/reads"}, 64'(rd_q.size()), 64'(n));
      chk({name, "/pops"}, 64'(pop_q.size()), 64'(n));
      if (n == 0) begin
         chk({name, "/done_cycle"}, 64'(done_cyc[0]), 64'(st + 1));
         chk({name, "/busy_seen"}, 64'(busy_seen), 0);
         return;
      end
      idx = 0;
      for (int rr = 0; rr < r; rr++) begin
         for (int cc = 0; cc < c; cc++) begin
            ea = AW'(int'(b) + rr * int'(s) + cc);
            ee = {1'(rr == r - 1 && cc == c - 1), 1'(cc == c - 1), mem_word(ea)};
            if (idx < rd_q.size()) chk($sformatf("%s/addr%0d", name, idx), 64'(rd_q[idx]), 64'(ea));
            if (idx < pop_q.size()) chk($sformatf("%s/elem%0d", name, idx), 64'(pop_q[idx]), 64'(ee));
            if (strict && idx > 0 && idx < rd_q.size())
               chk($sformatf("%s/rd_gap%0d", name, idx), 64'(rd_cyc[idx] - rd_cyc[idx-1]), 1);
            if (strict && idx > 0 && idx < pop_q.size())
               chk($sformatf("%s/pop_gap%0d", name, idx), 64'(pop_cyc[idx] - pop_cyc[idx-1]), 1);
            idx++;
         end
      end
      if (strict && rd_q.size() > 0) chk({name, "/first_read"}, 64'(rd_cyc[0]), 64'(st + 1));
      if (pop_q.size() == n) chk({name, "/done_cycle"}, 64'(done_cyc[0]), 64'(pop_cyc[n-1] + 1));
      chk({name, "/outstanding<=2"}, 64'(max_out <= 2), 1);
      chk({name, "/stall_stable"}, 64'(stall_bad), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d vectors applied", vectors);
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      reset_n = 1'b0;
      rdy_mode = 0;
      #12;
      chk_outputs_zero("reset");
      @(posedge clk); #1;
      reset_n = 1'b1;

      run_tile("basic", 16'h0100, 2, 3, 16'h0010, 1'b0, 1'b1);
      rdy_mode = 1;
      run_tile("bp_1001", 16'h0100, 2, 3, 16'h0010, 1'b0, 1'b0);
      rdy_mode = 0;
      run_tile("wrap", 16'hFFFE, 1, 4, 16'h0001, 1'b0, 1'b1);
      run_tile("cols0", 16'h0200, 3, 0, 16'h0004, 1'b0, 1'b0);
      run_tile("rows0", 16'h0200, 0, 5, 16'h0004, 1'b0, 1'b0);
      run_tile("busy_start", 16'h0300, 3, 2, 16'h0020, 1'b1, 1'b1);

      // reset in the middle of a 4x4 tile
      clear_log();
      @(posedge clk); #1;
      start = 1'b1; base_addr = 16'h0400; rows = 8'd4; cols = 8'd4; row_stride = 16'h0008;
      @(posedge clk); #1;
      start = 1'b0;
      k = 0;
      while (popped < 3 && k < 100) begin @(posedge clk); #1; k++; end
      chk("midreset/third_elem", 64'(popped >= 3), 1);
      reset_n = 1'b0;
      #1;
      chk_outputs_zero("midreset");
      @(posedge clk); @(posedge clk); #1;
      reset_n = 1'b1;
      run_tile("after_reset", 16'h0ABC, 1, 1, 16'h0001, 1'b0, 1'b1);

      rdy_mode = 2;
      for (int t = 0; t < 10; t++)
         run_tile($sformatf("rand%0d", t), AW'($urandom), int'($urandom_range(1, 4)),
                  int'($urandom_range(1, 5)), AW'($urandom), 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
